// File: rtl/stage_sequencer.sv
// Multi-cycle instruction sequencer: walks each instruction through
// fetch, decode, execute, memory, writeback and PC-update stages. It keeps
// the condition codes, the branch/cmov condition, the machine status and
// the retired-instruction count.
module stage_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  icode,
  input  logic [3:0]  ifun,
  input  logic        instr_valid,
  input  logic        imem_error,
  input  logic        mem_ack,
  input  logic        dmem_error,
  input  logic        alu_zf,
  input  logic        alu_sf,
  input  logic        alu_of,
  output logic        f_en,
  output logic        d_en,
  output logic        e_en,
  output logic        m_en,
  output logic        w_en,
  output logic        pc_en,
  output logic        mem_req,
  output logic        set_cc,
  output logic [2:0]  cc,
  output logic        Cnd,
  output logic [2:0]  stat,
  output logic        busy,
  output logic [31:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE,
    S_MEMORY, S_WRITEBACK, S_PCUPD, S_HALTED
  } state_t;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  state_t      state, state_nxt;
  logic [3:0]  icode_q, ifun_q;
  logic [3:0]  tmo_cnt;
  logic        latch_instr;
  logic        halt_req;
  logic [2:0]  halt_stat;
  logic        retire;
  logic        cnd_wr;
  logic        tmo_clr;

  // Opcode/function combinations the execute stage cannot handle.
  function automatic logic instr_illegal(input logic [3:0] ic, input logic [3:0] fn);
    return (ic > 4'hB) ||
           (((ic == 4'h2) || (ic == 4'h7)) && (fn > 4'h6)) ||
           ((ic == 4'h6) && (fn > 4'h3));
  endfunction

  // Instructions that touch data memory (rmmovq, mrmovq, call, ret, push, pop).
  function automatic logic uses_mem(input logic [3:0] ic);
    return (ic == 4'h4) || (ic == 4'h5) || (ic == 4'h8) ||
           (ic == 4'h9) || (ic == 4'hA) || (ic == 4'hB);
  endfunction

  // Branch / conditional-move condition from {ZF,SF,OF}.
  function automatic logic cond_eval(input logic [3:0] fn, input logic [2:0] flags);
    logic zf, lt;
    zf = flags[2];
    lt = flags[1] ^ flags[0];
    case (fn)
      4'h0:    return 1'b1;
      4'h1:    return lt | zf;
      4'h2:    return lt;
      4'h3:    return zf;
      4'h4:    return ~zf;
      4'h5:    return ~lt;
      4'h6:    return ~lt & ~zf;
      default: return 1'b0;
    endcase
  endfunction

  // Retire counter sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign busy = (state != S_IDLE) && (state != S_HALTED);

  // Next-state decode and per-state stage enables.
  always_comb begin
    state_nxt   = state;
    f_en        = 1'b0;
    d_en        = 1'b0;
    e_en        = 1'b0;
    m_en        = 1'b0;
    w_en        = 1'b0;
    pc_en       = 1'b0;
    mem_req     = 1'b0;
    set_cc      = 1'b0;
    latch_instr = 1'b0;
    halt_req    = 1'b0;
    halt_stat   = STAT_AOK;
    retire      = 1'b0;
    cnd_wr      = 1'b0;
    tmo_clr     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        f_en = 1'b1;
        if (instr_valid) begin
          latch_instr = 1'b1;
          if (imem_error) begin
            halt_req  = 1'b1;
            halt_stat = STAT_ADR;
          end else if (icode == 4'h0) begin
            halt_req  = 1'b1;
            halt_stat = STAT_HLT;
          end else if (instr_illegal(icode, ifun)) begin
            halt_req  = 1'b1;
            halt_stat = STAT_INS;
          end else begin
            state_nxt = S_DECODE;
          end
        end
      end
      S_DECODE: begin
        d_en      = 1'b1;
        state_nxt = S_EXECUTE;
      end
      S_EXECUTE: begin
        e_en      = 1'b1;
        set_cc    = (icode_q == 4'h6);
        cnd_wr    = (icode_q == 4'h2) || (icode_q == 4'h7);
        tmo_clr   = 1'b1;
        state_nxt = uses_mem(icode_q) ? S_MEMORY : S_WRITEBACK;
      end
      S_MEMORY: begin
        m_en    = 1'b1;
        mem_req = 1'b1;
        if (mem_ack) begin
          if (dmem_error) begin
            halt_req  = 1'b1;
            halt_stat = STAT_ADR;
          end else begin
            state_nxt = S_WRITEBACK;
          end
        end else if (tmo_cnt == 4'hF) begin
          // Sixteenth cycle without an ack: treat as an address fault.
          halt_req  = 1'b1;
          halt_stat = STAT_ADR;
        end
      end
      S_WRITEBACK: begin
        w_en      = 1'b1;
        state_nxt = S_PCUPD;
      end
      S_PCUPD: begin
        pc_en     = 1'b1;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_HALTED: begin
        state_nxt = S_HALTED;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    if (halt_req) state_nxt = S_HALTED;
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Fetched instruction fields, captured on the fetch handshake.
  always_ff @(posedge clk) begin
    if (latch_instr) begin
      icode_q <= icode;
      ifun_q  <= ifun;
    end
  end

  // Architectural status: stat, condition codes, Cnd, retire count, memory timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat        <= STAT_AOK;
      cc          <= 3'b100;
      Cnd         <= 1'b0;
      instr_count <= 32'd0;
      tmo_cnt     <= 4'd0;
    end else begin
      if (halt_req) stat        <= halt_stat;
      if (set_cc)   cc          <= {alu_zf, alu_sf, alu_of};
      if (cnd_wr)   Cnd         <= cond_eval(ifun_q, cc);
      if (retire)   instr_count <= sat_inc(instr_count);
      if (tmo_clr)                        tmo_cnt <= 4'd0;
      else if (m_en && !mem_ack)          tmo_cnt <= tmo_cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_stage_sequencer.sv
// Self-checking bench for stage_sequencer: a directed vector table, faults and
// reset corner cases, then randomized instructions against a stage-list model.
`timescale 1ns/1ps
module tb_stage_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  icode = 4'h0, ifun = 4'h0;
  logic        instr_valid = 1'b0, imem_error = 1'b0;
  logic        mem_ack = 1'b0, dmem_error = 1'b0;
  logic        alu_zf = 1'b0, alu_sf = 1'b0, alu_of = 1'b0;
  logic        f_en, d_en, e_en, m_en, w_en, pc_en, mem_req, set_cc, Cnd, busy;
  logic [2:0]  cc, stat;
  logic [31:0] instr_count;

  // Free-running clock, 10 ns period.
  always #5 clk = ~clk;

  stage_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .icode(icode), .ifun(ifun),
    .instr_valid(instr_valid), .imem_error(imem_error),
    .mem_ack(mem_ack), .dmem_error(dmem_error),
    .alu_zf(alu_zf), .alu_sf(alu_sf), .alu_of(alu_of),
    .f_en(f_en), .d_en(d_en), .e_en(e_en), .m_en(m_en), .w_en(w_en), .pc_en(pc_en),
    .mem_req(mem_req), .set_cc(set_cc), .cc(cc), .Cnd(Cnd), .stat(stat),
    .busy(busy), .instr_count(instr_count)
  );

  localparam int ST_F = 0, ST_D = 1, ST_E = 2, ST_M = 3, ST_W = 4, ST_P = 5;

  int checks = 0;
  int errors = 0;

  // Reference machine state.
  logic [2:0]  m_cc;
  logic        m_cnd;
  logic [31:0] m_cnt;
  logic [2:0]  m_stat;

  typedef struct {
    logic [3:0]  ic;
    logic [3:0]  fn;
    logic [2:0]  fl;
    int          fd;
    int          md;
    logic        ierr;
    logic        derr;
    int          cyc;
    logic [2:0]  cc;
    logic        cnd;
    logic [31:0] cnt;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic is_illegal(input logic [3:0] ic, input logic [3:0] fn);
    return (ic > 4'hB) || ((ic == 4'h2 || ic == 4'h7) && fn > 4'h6) || (ic == 4'h6 && fn > 4'h3);
  endfunction

  function automatic logic needs_mem(input logic [3:0] ic);
    return ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
  endfunction

  function automatic logic cond_of(input logic [3:0] fn, input logic [2:0] f);
    case (fn)
      4'h0: return 1'b1;
      4'h1: return (f[1] != f[0]) || f[2];
      4'h2: return f[1] != f[0];
      4'h3: return f[2];
      4'h4: return !f[2];
      4'h5: return f[1] == f[0];
      4'h6: return (f[1] == f[0]) && !f[2];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] quiet_vec();
    return {stat, f_en, d_en, e_en, m_en, w_en, pc_en, mem_req, set_cc, busy, cc, Cnd};
  endfunction

  task automatic idle_checks(input string tag);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk({tag, "_idle_outputs"}, 32'(quiet_vec()), 32'({3'd1, 9'd0, 3'b100, 1'b0}));
      chk({tag, "_idle_count"}, instr_count, 32'd0);
    end
  endtask

  task automatic reset_and_start();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; instr_valid = 1'b0; mem_ack = 1'b0;
    imem_error = 1'b0; dmem_error = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_cc = 3'b100; m_cnd = 1'b0; m_cnt = 32'd0; m_stat = 3'd1;
    idle_checks("reset");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Runs one instruction from the FETCH state, checking every cycle against the
  // stage list the model derives for it; returns the cycles with a stage enabled.
  task automatic run_instr(input logic [3:0] ic, input logic [3:0] fn, input logic [2:0] fl,
                           input int fd, input int md, input logic ierr, input logic derr,
                           output int cyc);
    int seq[$];
    int halt;
    int mi;
    logic fetch_ok;
    logic [5:0]  en;
    logic [11:0] want, got;
    seq = {}; halt = 0; cyc = 0; mi = 0;
    for (int i = 0; i <= fd; i++) seq.push_back(ST_F);
    fetch_ok = 1'b0;
    if (ierr) halt = 3;
    else if (ic == 4'h0) halt = 2;
    else if (is_illegal(ic, fn)) halt = 4;
    else begin
      fetch_ok = 1'b1;
      seq.push_back(ST_D);
      seq.push_back(ST_E);
      if (needs_mem(ic)) begin
        for (int i = 0; i < ((md >= 16) ? 16 : md + 1); i++) seq.push_back(ST_M);
        if (md >= 16 || derr) halt = 3;
      end
      if (halt == 0) begin
        seq.push_back(ST_W);
        seq.push_back(ST_P);
      end
    end
    {alu_zf, alu_sf, alu_of} = fl;
    imem_error = ierr;
    dmem_error = derr;
    foreach (seq[k]) begin
      en   = 6'b100000 >> seq[k];
      want = {3'd1, en, seq[k] == ST_M, (seq[k] == ST_E) && (ic == 4'h6), 1'b1};
      got  = {stat, f_en, d_en, e_en, m_en, w_en, pc_en, mem_req, set_cc, busy};
      chk($sformatf("stage ic%0h cyc%0d", ic, k), 32'(got), 32'(want));
      if (|{f_en, d_en, e_en, m_en, w_en, pc_en}) cyc++;
      instr_valid = (seq[k] == ST_F) && (k == fd);
      icode   = instr_valid ? ic : ~ic;
      ifun    = instr_valid ? fn : ~fn;
      mem_ack = (seq[k] == ST_M) && (mi == md);
      if (seq[k] == ST_M) mi++;
      @(posedge clk);
      @(negedge clk);
    end
    instr_valid = 1'b0; mem_ack = 1'b0; imem_error = 1'b0; dmem_error = 1'b0;
    if (fetch_ok) begin
      if (ic == 4'h2 || ic == 4'h7) m_cnd = cond_of(fn, m_cc);
      if (ic == 4'h6) m_cc = fl;
    end
    if (halt == 0 && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
    m_stat = (halt == 0) ? 3'd1 : 3'(halt);
    chk($sformatf("cc after ic%0h", ic), 32'(cc), 32'(m_cc));
    chk($sformatf("Cnd after ic%0h", ic), 32'(Cnd), 32'(m_cnd));
    chk($sformatf("stat after ic%0h", ic), 32'(stat), 32'(m_stat));
    chk($sformatf("count after ic%0h", ic), instr_count, m_cnt);
    chk($sformatf("busy after ic%0h", ic), 32'(busy), 32'(halt == 0));
  endtask

  // Start pulses must not wake a halted machine; all status frozen.
  task automatic check_halted();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("halted_outputs", 32'({f_en, d_en, e_en, m_en, w_en, pc_en, mem_req, set_cc, busy}), 32'd0);
    chk("halted_stat", 32'(stat), 32'(m_stat));
    chk("halted_cc", 32'(cc), 32'(m_cc));
    chk("halted_count", instr_count, m_cnt);
  endtask

  initial begin
    int cyc;
    logic [3:0] ic, fn;
    int r, fd, md;
    logic ierr, derr;

    tbl[0]  = '{4'h6, 4'h1, 3'b100, 0, 0,  1'b0, 1'b0, 5,  3'b100, 1'b0, 32'd1};
    tbl[1]  = '{4'h6, 4'h0, 3'b010, 0, 0,  1'b0, 1'b0, 5,  3'b010, 1'b0, 32'd2};
    tbl[2]  = '{4'h7, 4'h2, 3'b111, 0, 0,  1'b0, 1'b0, 5,  3'b010, 1'b1, 32'd3};
    tbl[3]  = '{4'h7, 4'h5, 3'b000, 0, 0,  1'b0, 1'b0, 5,  3'b010, 1'b0, 32'd4};
    tbl[4]  = '{4'h2, 4'h4, 3'b000, 0, 0,  1'b0, 1'b0, 5,  3'b010, 1'b1, 32'd5};
    tbl[5]  = '{4'h5, 4'h0, 3'b000, 0, 3,  1'b0, 1'b0, 9,  3'b010, 1'b1, 32'd6};
    tbl[6]  = '{4'h4, 4'h0, 3'b000, 2, 0,  1'b0, 1'b0, 8,  3'b010, 1'b1, 32'd7};
    tbl[7]  = '{4'h8, 4'h0, 3'b000, 0, 15, 1'b0, 1'b0, 21, 3'b010, 1'b1, 32'd8};
    tbl[8]  = '{4'h1, 4'h0, 3'b000, 1, 0,  1'b0, 1'b0, 6,  3'b010, 1'b1, 32'd9};
    tbl[9]  = '{4'h6, 4'h2, 3'b001, 0, 0,  1'b0, 1'b0, 5,  3'b001, 1'b1, 32'd10};
    tbl[10] = '{4'h7, 4'h6, 3'b000, 0, 0,  1'b0, 1'b0, 5,  3'b001, 1'b0, 32'd11};
    tbl[11] = '{4'h9, 4'h0, 3'b000, 0, 1,  1'b0, 1'b0, 7,  3'b001, 1'b0, 32'd12};

    #1 rst_n = 1'b0;

    // Directed vector table in one run from reset.
    reset_and_start();
    foreach (tbl[i]) begin
      run_instr(tbl[i].ic, tbl[i].fn, tbl[i].fl, tbl[i].fd, tbl[i].md, tbl[i].ierr, tbl[i].derr, cyc);
      chk($sformatf("vec%0d_cycles", i), 32'(cyc), 32'(tbl[i].cyc));
      chk($sformatf("vec%0d_cc", i), 32'(cc), 32'(tbl[i].cc));
      chk($sformatf("vec%0d_Cnd", i), 32'(Cnd), 32'(tbl[i].cnd));
      chk($sformatf("vec%0d_count", i), instr_count, tbl[i].cnt);
    end

    // Fetch faults.
    reset_and_start();
    run_instr(4'h6, 4'h1, 3'b100, 0, 0, 1'b0, 1'b0, cyc);
    run_instr(4'h0, 4'h0, 3'b000, 0, 0, 1'b0, 1'b0, cyc);
    chk("halt_stat", 32'(stat), 32'd2);
    check_halted();
    reset_and_start();
    run_instr(4'hC, 4'h0, 3'b000, 1, 0, 1'b0, 1'b0, cyc);
    chk("badop_stat", 32'(stat), 32'd4);
    check_halted();
    reset_and_start();
    run_instr(4'h7, 4'h7, 3'b000, 0, 0, 1'b0, 1'b0, cyc);
    chk("badfn_stat", 32'(stat), 32'd4);
    check_halted();
    reset_and_start();
    run_instr(4'h6, 4'h0, 3'b000, 0, 0, 1'b1, 1'b0, cyc);
    chk("imem_err_stat", 32'(stat), 32'd3);
    check_halted();

    // Memory hang and data fault.
    reset_and_start();
    run_instr(4'h6, 4'h1, 3'b011, 0, 0, 1'b0, 1'b0, cyc);
    run_instr(4'h5, 4'h0, 3'b000, 0, 99, 1'b0, 1'b0, cyc);
    chk("hang_stat", 32'(stat), 32'd3);
    chk("hang_count", instr_count, 32'd1);
    chk("hang_mem_req", 32'(mem_req), 32'd0);
    check_halted();
    reset_and_start();
    run_instr(4'h4, 4'h0, 3'b000, 0, 2, 1'b0, 1'b1, cyc);
    chk("dmem_err_stat", 32'(stat), 32'd3);
    chk("dmem_err_count", instr_count, 32'd0);
    check_halted();

    // Asynchronous reset in the middle of a memory wait.
    reset_and_start();
    icode = 4'h5; ifun = 4'h0; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_mem_req", 32'(mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", 32'(quiet_vec()), 32'({3'd1, 9'd0, 3'b100, 1'b0}));
    chk("async_reset_count", instr_count, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_cc = 3'b100; m_cnd = 1'b0; m_cnt = 32'd0; m_stat = 3'd1;
    idle_checks("post_async");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_instr(4'h3, 4'h0, 3'b000, 0, 0, 1'b0, 1'b0, cyc);

    // Randomized instruction stream.
    reset_and_start();
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 19);
      if (r < 18) ic = 4'($urandom_range(1, 11));
      else if (r == 18) ic = 4'h0;
      else ic = 4'($urandom_range(12, 15));
      if (ic == 4'h2 || ic == 4'h7) fn = 4'($urandom_range(0, 7));
      else if (ic == 4'h6) fn = 4'($urandom_range(0, 4));
      else fn = 4'($urandom_range(0, 15));
      fd   = $urandom_range(0, 2);
      md   = ($urandom_range(0, 20) == 20) ? 18 : $urandom_range(0, 4);
      ierr = ($urandom_range(0, 30) == 0);
      derr = ($urandom_range(0, 20) == 0);
      run_instr(ic, fn, 3'($urandom_range(0, 7)), fd, md, ierr, derr, cyc);
      if (m_stat != 3'd1) begin
        check_halted();
        reset_and_start();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stage_sequencer.md
STAGE_SEQUENCER -- requirements
Module: stage_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state changes on rising edge.
REQ-002 SHALL have ports: rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: start  in  1  begin execution from IDLE.
REQ-004 SHALL have ports: icode, ifun  in  4 each  fields of fetched instruction, sampled when instr_valid=1.
REQ-005 SHALL have ports: instr_valid  in  1  fetch done; imem_error  in  1  fetch address fault, qualified by instr_valid.
REQ-006 SHALL have ports: mem_ack  in  1  data memory done; dmem_error  in  1  data fault, qualified by mem_ack.
REQ-007 SHALL have ports: alu_zf, alu_sf, alu_of  in  1 each  flags computed by the execute ALU this cycle.
REQ-008 SHALL have ports: f_en, d_en, e_en, m_en, w_en, pc_en  out  1 each  stage enables, at most one high per cycle.
REQ-009 SHALL have ports: mem_req  out  1  data memory request; set_cc  out  1  CC write strobe.
REQ-010 SHALL have ports: cc  out  3  {ZF,SF,OF}; Cnd  out  1  registered branch/cmov condition.
REQ-011 SHALL have ports: stat  out  3  1=AOK, 2=HLT, 3=ADR, 4=INS; busy  out  1  not in IDLE/HALTED; instr_count  out  32  retired instructions.

Function
REQ-012 SHALL implement states IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALTED; one-hot or binary is free.
REQ-013 IDLE: all enables 0; start=1 -> FETCH next cycle.
REQ-014 FETCH: f_en=1 while waiting; on instr_valid latch icode/ifun; if imem_error -> stat=3, HALTED; else if icode=0 -> stat=2, HALTED; else if icode>0xB, or icode in {2,7} with ifun>6, or icode=6 with ifun>3 -> stat=4, HALTED; else DECODE.
REQ-015 DECODE, EXECUTE, WRITEBACK, PCUPD SHALL each last exactly one cycle with its enable high.
REQ-016 EXECUTE: Cnd evaluated from cc held at entry (pre-update): ifun 0 always, 1 le (SF^OF)|ZF, 2 l SF^OF, 3 e ZF, 4 ne ~ZF, 5 ge ~(SF^OF), 6 g ~(SF^OF)&~ZF; Cnd updated only for icode 2/7, else held.
REQ-017 EXECUTE: set_cc=1 only when icode=6; cc <= {alu_zf,alu_sf,alu_of} at that edge; no other icode modifies cc.
REQ-018 After EXECUTE: icode in {4,5,8,9,A,B} -> MEMORY; others -> WRITEBACK.
REQ-019 MEMORY: m_en=1 and mem_req=1 held until mem_ack; on mem_ack without dmem_error -> WRITEBACK; with dmem_error -> stat=3, HALTED, no WRITEBACK/PCUPD.
REQ-020 MEMORY timeout: 4-bit counter cleared on MEMORY entry, increments each cycle without ack; 16th cycle without ack -> stat=3, HALTED; ack on 16th cycle wins.
REQ-021 PCUPD: pc_en=1, instr_count += 1 saturating at 0xFFFFFFFF, then FETCH.
REQ-022 Minimum latency per instruction with same-cycle instr_valid/mem_ack: 5 cycles no-memory, 6 cycles with memory.
REQ-023 HALTED: all enables, mem_req, set_cc 0; stat, cc, instr_count frozen; start ignored; exit only by reset.
REQ-024 stat SHALL be 1 whenever not HALTED after first start.

Reset
REQ-025 rst_n=0 SHALL asynchronously force IDLE, all enables/mem_req/set_cc=0, cc={1,0,0}, Cnd=0, stat=1, instr_count=0, timeout=0.
REQ-026 Reset asserted mid-MEMORY SHALL drop mem_req immediately, no retire counted.
REQ-027 After rst_n deassertion, block SHALL stay in IDLE until start=1 sampled high.

Verification
REQ-028 OPq: start, icode=6 ifun=1, alu flags {1,0,0}, instr_valid same cycle -> f,d,e,w,pc enables in 5 consecutive cycles, set_cc pulse in EXECUTE, cc=3'b100, instr_count=1.
REQ-029 Branch: cc={0,1,0}, icode=7 ifun=2 -> Cnd=1; ifun=5 -> Cnd=0; cc unchanged.
REQ-030 mrmovq with mem_ack delayed 3 cycles -> mem_req high 4 cycles, 9-cycle instruction, count increments once.
REQ-031 Memory hang: icode=5, mem_ack never -> HALTED after 16 MEMORY cycles, stat=3, mem_req low, count unchanged.
REQ-032 Faults: icode=0 -> stat=2; icode=0xC -> stat=4; imem_error -> stat=3; each HALTED, start re-pulse ignored.
REQ-033 Async reset asserted mid-MEMORY -> outputs at reset values before next clk edge, IDLE after release.
